// File: rtl/execute_stage_md.sv
// execute_stage_md: pipeline execute stage with a forwarding mux, a single-cycle ALU,
// an EX/MEM output register and an iterative multiply/divide unit owning HI/LO.
//
// Optional feature: define EXECUTE_STAGE_MD_DIV_EN to compile in the divider. Without it
// DIV/DIVU are accepted but do nothing and o_div_zero is tied low.
//
// Ports:
//   clk, i_rst_n              clock, asynchronous active-low reset
//   i_stall, i_flush          hold / bubble the EX/MEM register (flush wins)
//   i_valid                   instruction present in ID/EX
//   i_reg_a, i_reg_b          register operands
//   i_fwd_exmem, i_fwd_memwb  forwarded values
//   i_imm, i_imm_sel          extended immediate, select it as operand B
//   i_fw_a, i_fw_b            forward selects (00 reg, 10 MEM/WB, 11 EX/MEM, 01 zero)
//   i_shamt, i_alu_op         shift amount, ALU opcode
//   i_md_op                   multiply/divide opcode
//   i_wr_reg, i_reg_write, i_mem_read, i_mem_write   control passthrough
//   o_valid .. o_data4mem     EX/MEM register
//   o_busy                    multiply/divide in flight
//   o_div_zero                one-cycle divide-by-zero pulse
module execute_stage_md #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_reg_a,
    input  logic [NB_DATA-1:0] i_reg_b,
    input  logic [NB_DATA-1:0] i_fwd_exmem,
    input  logic [NB_DATA-1:0] i_fwd_memwb,
    input  logic [NB_DATA-1:0] i_imm,
    input  logic [1:0]         i_fw_a,
    input  logic [1:0]         i_fw_b,
    input  logic               i_imm_sel,
    input  logic [4:0]         i_shamt,
    input  logic [3:0]         i_alu_op,
    input  logic [2:0]         i_md_op,
    input  logic [NB_REG-1:0]  i_wr_reg,
    input  logic               i_reg_write,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    output logic               o_valid,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic [NB_REG-1:0]  o_wr_reg,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_DATA-1:0] o_data4mem,
    output logic               o_busy,
    output logic               o_div_zero
);

    localparam int unsigned CW = $clog2(NB_DATA);

    localparam logic [2:0] MdMult  = 3'd1;
    localparam logic [2:0] MdMultu = 3'd2;
    localparam logic [2:0] MdDiv   = 3'd3;
    localparam logic [2:0] MdDivu  = 3'd4;
    localparam logic [2:0] MdMfhi  = 3'd5;
    localparam logic [2:0] MdMflo  = 3'd6;
    localparam logic [2:0] MdMtlo  = 3'd7;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} md_state_e;

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NB_DATA-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [NB_DATA-1:0] work_hi_q, work_hi_d, work_lo_q, work_lo_d;
    logic [NB_DATA-1:0] opnd_q, opnd_d;
    logic               neg_q, neg_d;

    logic [NB_DATA-1:0] op_a, fwd_b, op_b, alu_res, ex_result;

    // Forwarding muxes
    always_comb begin
        op_a = '0;
        case (i_fw_a)
            2'b00:   op_a = i_reg_a;
            2'b10:   op_a = i_fwd_memwb;
            2'b11:   op_a = i_fwd_exmem;
            default: op_a = '0;
        endcase
        fwd_b = '0;
        case (i_fw_b)
            2'b00:   fwd_b = i_reg_b;
            2'b10:   fwd_b = i_fwd_memwb;
            2'b11:   fwd_b = i_fwd_exmem;
            default: fwd_b = '0;
        endcase
        op_b = i_imm_sel ? i_imm : fwd_b;
    end

    always_comb begin
        alu_res = '0;
        case (i_alu_op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = ~(op_a | op_b);
            4'd6:    alu_res = {{(NB_DATA-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd7:    alu_res = {{(NB_DATA-1){1'b0}}, op_a < op_b};
            4'd8:    alu_res = op_b << i_shamt;
            4'd9:    alu_res = op_b >> i_shamt;
            4'd10:   alu_res = $unsigned($signed(op_b) >>> i_shamt);
            4'd11:   alu_res = {i_imm[NB_DATA/2-1:0], {(NB_DATA/2){1'b0}}};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        ex_result = alu_res;
        if (i_md_op == MdMfhi) ex_result = hi_q;
        else if (i_md_op == MdMflo) ex_result = lo_q;
    end

    logic issue, md_idle, start_mul, start_div, div_zero, is_signed, a_neg, b_neg, md_nowb;
    logic [NB_DATA-1:0] a_abs, b_abs;

    assign issue     = i_valid & ~i_stall;
    assign md_idle   = (state_q == StIdle);
    assign start_mul = issue & md_idle & ((i_md_op == MdMult) | (i_md_op == MdMultu));
    assign is_signed = (i_md_op == MdMult) | (i_md_op == MdDiv);
    assign a_neg     = is_signed & op_a[NB_DATA-1];
    assign b_neg     = is_signed & op_b[NB_DATA-1];
    assign a_abs     = a_neg ? -op_a : op_a;
    assign b_abs     = b_neg ? -op_b : op_b;
    assign md_nowb   = (i_md_op inside {MdMult, MdMultu, MdDiv, MdDivu, MdMtlo});

    // Shift-add multiplier step: {work_hi, work_lo} holds partial product and multiplier
    logic [NB_DATA:0]     mul_sum;
    logic [NB_DATA-1:0]   mul_hi_n, mul_lo_n;
    logic [2*NB_DATA-1:0] prod;
    assign mul_sum  = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi_n = mul_sum[NB_DATA:1];
    assign mul_lo_n = {mul_sum[0], work_lo_q[NB_DATA-1:1]};

`ifdef EXECUTE_STAGE_MD_DIV_EN
    logic             div_req, neg_rem_q, neg_rem_d, div_ge, div_zero_q;
    logic [NB_DATA:0] rem_sh, div_diff;
    logic [NB_DATA-1:0] div_hi_n, div_lo_n;
    assign div_req   = issue & md_idle & ((i_md_op == MdDiv) | (i_md_op == MdDivu));
    assign div_zero  = div_req & (op_b == '0);
    assign start_div = div_req & ~div_zero;
    // Restoring divider step: remainder in work_hi, dividend shifts out of work_lo
    assign rem_sh    = {work_hi_q, work_lo_q[NB_DATA-1]};
    assign div_diff  = rem_sh - {1'b0, opnd_q};
    assign div_ge    = ~div_diff[NB_DATA];
    assign div_hi_n  = div_ge ? div_diff[NB_DATA-1:0] : rem_sh[NB_DATA-1:0];
    assign div_lo_n  = {work_lo_q[NB_DATA-2:0], div_ge};
`else
    assign div_zero  = 1'b0;
    assign start_div = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        prod      = '0;
`ifdef EXECUTE_STAGE_MD_DIV_EN
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_mul) begin
                    state_d   = StMul;
                    cnt_d     = CW'(NB_DATA - 1);
                    work_hi_d = '0;
                    work_lo_d = b_abs;
                    opnd_d    = a_abs;
                    neg_d     = a_neg ^ b_neg;
                end else if (start_div) begin
                    state_d   = StDiv;
                    cnt_d     = CW'(NB_DATA - 1);
                    work_hi_d = '0;
                    work_lo_d = a_abs;
                    opnd_d    = b_abs;
                    neg_d     = a_neg ^ b_neg;
`ifdef EXECUTE_STAGE_MD_DIV_EN
                    neg_rem_d = a_neg;
`endif
                end else if (issue && i_md_op == MdMtlo) begin
                    lo_d = op_a;
                end
            end
            StMul: begin
                work_hi_d = mul_hi_n;
                work_lo_d = mul_lo_n;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    prod    = {mul_hi_n, mul_lo_n};
                    if (neg_q) prod = -prod;
                    hi_d = prod[2*NB_DATA-1:NB_DATA];
                    lo_d = prod[NB_DATA-1:0];
                end
            end
`ifdef EXECUTE_STAGE_MD_DIV_EN
            StDiv: begin
                work_hi_d = div_hi_n;
                work_lo_d = div_lo_n;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    lo_d    = neg_q ? -div_lo_n : div_lo_n;
                    hi_d    = neg_rem_q ? -div_hi_n : div_hi_n;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
        end
    end

`ifdef EXECUTE_STAGE_MD_DIV_EN
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero;
        end
    end
    assign o_div_zero = div_zero_q;
`else
    assign o_div_zero = 1'b0;
`endif

    assign o_busy = ~md_idle;

    // EX/MEM register: flush beats stall; a non-stalled empty slot loads a bubble
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_wr_reg    <= '0;
            o_result    <= '0;
            o_data4mem  <= '0;
        end else if (i_flush) begin
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
        end else if (!i_stall) begin
            o_valid     <= i_valid;
            o_reg_write <= i_valid & i_reg_write & (i_wr_reg != '0) & ~md_nowb;
            o_mem_read  <= i_valid & i_mem_read;
            o_mem_write <= i_valid & i_mem_write;
            o_wr_reg    <= i_wr_reg;
            o_result    <= ex_result;
            o_data4mem  <= fwd_b;
        end
    end

endmodule

// File: tb/tb_execute_stage_md.sv
// tb_execute_stage_md: directed-vector bench for execute_stage_md (NB_DATA=32).
// Divider vectors are selected by EXECUTE_STAGE_MD_DIV_EN, matching the RTL build.
module tb_execute_stage_md;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall, i_flush, i_valid;
    logic [31:0] i_reg_a, i_reg_b, i_fwd_exmem, i_fwd_memwb, i_imm;
    logic [1:0]  i_fw_a, i_fw_b;
    logic        i_imm_sel;
    logic [4:0]  i_shamt;
    logic [3:0]  i_alu_op;
    logic [2:0]  i_md_op;
    logic [4:0]  i_wr_reg;
    logic        i_reg_write, i_mem_read, i_mem_write;
    logic        o_valid, o_reg_write, o_mem_read, o_mem_write;
    logic [4:0]  o_wr_reg;
    logic [31:0] o_result, o_data4mem;
    logic        o_busy, o_div_zero;

    int n_vec = 0;
    int n_err = 0;

    execute_stage_md #(.NB_DATA(32), .NB_REG(5)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_reg_a(i_reg_a), .i_reg_b(i_reg_b),
        .i_fwd_exmem(i_fwd_exmem), .i_fwd_memwb(i_fwd_memwb), .i_imm(i_imm),
        .i_fw_a(i_fw_a), .i_fw_b(i_fw_b), .i_imm_sel(i_imm_sel), .i_shamt(i_shamt),
        .i_alu_op(i_alu_op), .i_md_op(i_md_op), .i_wr_reg(i_wr_reg),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .o_valid(o_valid), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_wr_reg(o_wr_reg), .o_result(o_result),
        .o_data4mem(o_data4mem), .o_busy(o_busy), .o_div_zero(o_div_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_stall = 0; i_flush = 0; i_valid = 0;
        i_reg_a = 0; i_reg_b = 0; i_fwd_exmem = 0; i_fwd_memwb = 0; i_imm = 0;
        i_fw_a = 2'b00; i_fw_b = 2'b00; i_imm_sel = 0; i_shamt = 0;
        i_alu_op = 0; i_md_op = 0; i_wr_reg = 0;
        i_reg_write = 0; i_mem_read = 0; i_mem_write = 0;
    endtask

    // One ALU instruction with register operands (imm_sel selects i_imm for B)
    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm, input logic isel,
                           input logic [4:0] sh, input logic [31:0] exp);
        idle_inputs();
        i_valid = 1; i_alu_op = op; i_reg_a = a; i_reg_b = b; i_imm = imm;
        i_imm_sel = isel; i_shamt = sh; i_reg_write = 1; i_wr_reg = 5'd4;
        tick();
        check_eq(tag, o_result, exp);
    endtask

    // Issue a md op, then wait (bounded) for o_busy to drop; returns busy cycle count
    task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cycles);
        idle_inputs();
        i_valid = 1; i_md_op = op; i_reg_a = a; i_reg_b = b;
        i_reg_write = 1; i_wr_reg = 5'd5;
        tick();
        idle_inputs();
        cycles = 0;
        while (o_busy && cycles < 100) begin
            cycles++;
            tick();
        end
        check_eq({tag, "_done"}, 32'(o_busy), 0);
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        idle_inputs();
        i_valid = 1; i_md_op = 3'd5; i_reg_write = 1; i_wr_reg = 5'd2;
        tick();
        check_eq({tag, "_hi"}, o_result, exp_hi);
        i_md_op = 3'd6;
        tick();
        check_eq({tag, "_lo"}, o_result, exp_lo);
        idle_inputs();
    endtask

    initial begin
        int cyc;
        idle_inputs();
        i_rst_n = 0;
        tick();
        tick();
        check_eq("rst_valid", 32'(o_valid), 0);
        check_eq("rst_result", o_result, 0);
        check_eq("rst_regwr", 32'(o_reg_write), 0);
        check_eq("rst_busy", 32'(o_busy), 0);
        check_eq("rst_divz", 32'(o_div_zero), 0);
        i_rst_n = 1;
        tick();

        // ADD A=7, B=imm 5
        idle_inputs();
        i_valid = 1; i_reg_a = 7; i_imm = 5; i_imm_sel = 1; i_reg_b = 32'h55;
        i_reg_write = 1; i_wr_reg = 5'd3; i_mem_write = 1;
        tick();
        check_eq("add_res", o_result, 12);
        check_eq("add_valid", 32'(o_valid), 1);
        check_eq("add_regwr", 32'(o_reg_write), 1);
        check_eq("add_wrreg", 32'(o_wr_reg), 3);
        check_eq("add_d4m", o_data4mem, 32'h55);
        check_eq("add_memwr", 32'(o_mem_write), 1);

        // SUB with A forwarded from EX/MEM
        idle_inputs();
        i_valid = 1; i_alu_op = 1; i_fw_a = 2'b11; i_fwd_exmem = 32'h10; i_reg_b = 3;
        tick();
        check_eq("sub_fwd", o_result, 32'hD);

        alu_vec("and",  4'd2,  32'hF0F0, 32'h0FF0, 0, 0, 0, 32'h00F0);
        alu_vec("or",   4'd3,  32'hF0F0, 32'h0FF0, 0, 0, 0, 32'hFFF0);
        alu_vec("xor",  4'd4,  32'hF0F0, 32'h0FF0, 0, 0, 0, 32'hFF00);
        alu_vec("nor",  4'd5,  0, 0, 0, 0, 0, 32'hFFFF_FFFF);
        alu_vec("slt",  4'd6,  32'hFFFF_FFFF, 1, 0, 0, 0, 1);
        alu_vec("sltu", 4'd7,  32'hFFFF_FFFF, 1, 0, 0, 0, 0);
        alu_vec("sll",  4'd8,  0, 1, 0, 0, 5'd31, 32'h8000_0000);
        alu_vec("srl",  4'd9,  0, 32'h8000_0000, 0, 0, 5'd4, 32'h0800_0000);
        alu_vec("sra",  4'd10, 0, 32'h8000_0000, 0, 0, 5'd4, 32'hF800_0000);
        alu_vec("lui",  4'd11, 0, 0, 32'h0000_1234, 1, 0, 32'h1234_0000);
        alu_vec("undef", 4'd12, 5, 6, 0, 0, 0, 0);

        // Forward selects: A zero, B from MEM/WB; write to r0 must not write back
        idle_inputs();
        i_valid = 1; i_fw_a = 2'b01; i_reg_a = 99; i_fw_b = 2'b10; i_fwd_memwb = 32'h21;
        i_reg_write = 1; i_wr_reg = 5'd0;
        tick();
        check_eq("fwd_zero_memwb", o_result, 32'h21);
        check_eq("r0_regwr", 32'(o_reg_write), 0);

        // Stall holds EX/MEM; flush with stall inserts a bubble
        idle_inputs();
        i_valid = 1; i_reg_a = 40; i_reg_b = 2; i_reg_write = 1; i_wr_reg = 5'd6;
        tick();
        i_reg_a = 1; i_reg_b = 1; i_stall = 1;
        tick();
        check_eq("stall_hold", o_result, 42);
        check_eq("stall_valid", 32'(o_valid), 1);
        i_flush = 1;
        tick();
        check_eq("flush_valid", 32'(o_valid), 0);
        check_eq("flush_regwr", 32'(o_reg_write), 0);

        // MULT -1 x 2
        idle_inputs();
        i_valid = 1; i_md_op = 3'd1; i_reg_a = 32'hFFFF_FFFF; i_reg_b = 2;
        i_reg_write = 1; i_wr_reg = 5'd5;
        tick();
        check_eq("mult_regwr", 32'(o_reg_write), 0);
        idle_inputs();
        cyc = 0;
        while (o_busy && cyc < 100) begin
            cyc++;
            tick();
        end
        check_eq("mult_busy_cycles", cyc, 32);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        md_run("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check_eq("multu_cycles", cyc, 32);
        read_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        md_run("mult_mix", 3'd1, 32'hFFFF_FFFD, 32'd7, cyc);
        read_hilo("mult_mix", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // MTLO
        idle_inputs();
        i_valid = 1; i_md_op = 3'd7; i_reg_a = 32'hABCD;
        tick();
        read_hilo("mtlo", 32'hFFFF_FFFF, 32'hABCD);

`ifdef EXECUTE_STAGE_MD_DIV_EN
        md_run("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, cyc);
        check_eq("div_cycles", cyc, 32);
        read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md_run("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        read_hilo("div_ovf", 0, 32'h8000_0000);
        md_run("divu", 3'd4, 32'd100, 32'd7, cyc);
        read_hilo("divu", 32'd2, 32'd14);
        idle_inputs();
        i_valid = 1; i_md_op = 3'd4; i_reg_a = 5; i_reg_b = 0;
        tick();
        idle_inputs();
        check_eq("dz_pulse", 32'(o_div_zero), 1);
        check_eq("dz_busy", 32'(o_busy), 0);
        tick();
        check_eq("dz_end", 32'(o_div_zero), 0);
        read_hilo("dz", 32'd2, 32'd14);
`else
        idle_inputs();
        i_valid = 1; i_md_op = 3'd3; i_reg_a = 7; i_reg_b = 2;
        tick();
        idle_inputs();
        check_eq("nodiv_busy", 32'(o_busy), 0);
        check_eq("nodiv_dz", 32'(o_div_zero), 0);
        i_valid = 1; i_md_op = 3'd4; i_reg_a = 5; i_reg_b = 0;
        tick();
        idle_inputs();
        check_eq("nodiv_dz0", 32'(o_div_zero), 0);
        read_hilo("nodiv", 32'hFFFF_FFFF, 32'hABCD);
`endif

        // Reset mid-MULTU abandons it and clears HI/LO
        idle_inputs();
        i_valid = 1; i_md_op = 3'd2; i_reg_a = 3; i_reg_b = 5;
        tick();
        idle_inputs();
        for (int k = 0; k < 10; k++) tick();
        check_eq("pre_rst_busy", 32'(o_busy), 1);
        i_rst_n = 0;
        #1;
        check_eq("rst_mid_busy", 32'(o_busy), 0);
        check_eq("rst_mid_result", o_result, 0);
        tick();
        i_rst_n = 1;
        tick();
        read_hilo("rst_mid", 0, 0);
        tick();
        check_eq("rst_mid_idle", 32'(o_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/execute_stage_md.md
EXECUTE_STAGE_MD -- requirements
Module: execute_stage_md

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, meaning datapath width in bits (even, ≥8).
REQ-002 The block SHALL have parameter NB_REG, default 5, meaning register-index width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 The block SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports i_stall  input  1  hold EX/MEM register; i_flush  input  1  load bubble into EX/MEM register.
REQ-006 The block SHALL have port i_valid  input  1  instruction present in ID/EX.
REQ-007 The block SHALL have ports i_reg_a, i_reg_b, i_fwd_exmem, i_fwd_memwb, i_imm  input  NB_DATA  operands, forwarded values, extended immediate.
REQ-008 The block SHALL have ports i_fw_a, i_fw_b  input  2  forward select: 00 register, 10 MEM/WB, 11 EX/MEM, 01 zero.
REQ-009 The block SHALL have ports i_imm_sel  input  1  B operand = i_imm; i_shamt  input  5  shift amount.
REQ-010 The block SHALL have port i_alu_op  input  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 SLTU,8 SLL,9 SRL,10 SRA,11 LUI, others pass zero.
REQ-011 The block SHALL have port i_md_op  input  3  0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTLO.
REQ-012 The block SHALL have ports i_wr_reg  input  NB_REG; i_reg_write, i_mem_read, i_mem_write  input  1  control passthrough.
REQ-013 The block SHALL have outputs o_valid, o_reg_write, o_mem_read, o_mem_write  1; o_wr_reg  NB_REG; o_result, o_data4mem  NB_DATA (EX/MEM register).
REQ-014 The block SHALL have outputs o_busy  1  multiply/divide in flight; o_div_zero  1  one-cycle divide-by-zero pulse.

Function
REQ-015 Operand A = forward-mux(i_fw_a); B = i_imm if i_imm_sel else forward-mux(i_fw_b); o_data4mem captures the forward-muxed B regardless of i_imm_sel.
REQ-016 ALU ops SHALL be combinational, result registered into o_result one cycle after issue; shifts use i_shamt, SLT signed, SLTU unsigned, LUI = {i_imm[15:0], 16'b0} for NB_DATA=32 (low half zero generally).
REQ-017 Issue = i_valid & !i_stall; on issue EX/MEM register loads; i_stall holds all EX/MEM outputs; i_flush (priority over stall) loads o_valid=0 and all write/mem enables 0.
REQ-018 o_reg_write SHALL be forced 0 when i_wr_reg is zero.
REQ-019 MFHI/MFLO SHALL register HI/LO into o_result; MTLO writes A into LO; MULT/DIV instructions themselves leave EX/MEM with o_reg_write=0.
REQ-020 Multiply/divide FSM states IDLE, MUL, DIV: issue of MULT/MULTU -> MUL, DIV/DIVU -> DIV; counter loaded NB_DATA-1, decrements per cycle; at zero the FSM writes HI/LO and returns to IDLE.
REQ-021 o_busy SHALL be 1 exactly while FSM ≠ IDLE (NB_DATA cycles after issue cycle); HI/LO valid the cycle o_busy falls.
REQ-022 FSM SHALL advance independent of i_stall and i_flush; issue of any md op while o_busy is ignored (hazard unit must stall).
REQ-023 MULT: signed 2·NB_DATA product, HI=upper, LO=lower; MULTU unsigned.
REQ-024 DIV: LO=quotient truncated toward zero, HI=remainder with sign of dividend; most-negative / -1 gives LO=most-negative, HI=0; DIVU unsigned.
REQ-025 Divide by zero: FSM stays IDLE, HI/LO unchanged, o_div_zero pulses 1 cycle after issue.

Reset
REQ-026 Reset SHALL asynchronously clear o_valid, o_reg_write, o_mem_read, o_mem_write, o_wr_reg, o_result, o_data4mem, o_div_zero, HI, LO, counter to 0 and FSM to IDLE (o_busy=0); reset mid-operation abandons the operation.

Configuration
REQ-027 With macro EXECUTE_STAGE_MD_DIV_EN defined the divider SHALL be compiled in; undefined, DIV/DIVU SHALL not start the FSM, leave HI/LO unchanged, and o_div_zero SHALL be tied 0.

Verification
REQ-028 ADD A=7, B=imm 5, fw 00 -> next cycle o_result=12, o_valid=1.
REQ-029 i_fw_a=11, i_fwd_exmem=0x10, SUB B=0x3 -> o_result=0xD.
REQ-030 MULT 0xFFFFFFFF×2 -> o_busy high 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MFLO -> 0xFFFFFFFE.
REQ-031 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-032 DIVU 5/0 -> o_div_zero one-cycle pulse, o_busy stays 0, HI/LO unchanged.
REQ-033 Reset asserted at cycle 10 of MULTU -> o_busy=0, HI=LO=0 immediately; i_flush with i_stall -> o_valid=0.
